// File: rtl/rst_seq_if.sv
// Trigger inputs and reset/status outputs of the multi-domain reset sequencer.
interface rst_seq_if #(
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned ESC_LIMIT   = 3
);
  localparam int unsigned ESC_W = $clog2(ESC_LIMIT + 1);

  logic                   i_wdg_to;
  logic                   i_sw_req;
  logic                   i_esc_clr;
  logic [NUM_DOMAINS-1:0] o_dom_res_n;
  logic                   o_busy;
  logic [1:0]             o_cause;
  logic [ESC_W-1:0]       o_esc_cnt;
  logic                   o_fatal;

  modport master (
    output i_wdg_to, i_sw_req, i_esc_clr,
    input  o_dom_res_n, o_busy, o_cause, o_esc_cnt, o_fatal
  );

  modport slave (
    input  i_wdg_to, i_sw_req, i_esc_clr,
    output o_dom_res_n, o_busy, o_cause, o_esc_cnt, o_fatal
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: releases domains in index order with per-domain
// hold and inter-domain padding, restarts on watchdog/software edges, escalates to FATAL.
module rst_seq_ctrl #(
  parameter int unsigned                       NUM_DOMAINS    = 2,
  parameter int unsigned                       CNT_WIDTH      = 8,
  parameter logic [NUM_DOMAINS*CNT_WIDTH-1:0]  DOMAIN_HOLD    = {8'd60, 8'd5},
  parameter int unsigned                       PADDING_CYCLES = 1,
  parameter int unsigned                       ESC_LIMIT      = 3
) (
  input  logic     clk,
  input  logic     res_n,
  rst_seq_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int unsigned ESC_W = $clog2(ESC_LIMIT + 1);

  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_WIDTH-1:0] PAD_LAST  =
    CNT_WIDTH'((PADDING_CYCLES == 0) ? 0 : PADDING_CYCLES - 1);
  localparam logic [ESC_W-1:0]     ESC_MAX   = ESC_W'(ESC_LIMIT);
  localparam logic [1:0]           CAUSE_POR = 2'b00;
  localparam logic [1:0]           CAUSE_WDG = 2'b01;
  localparam logic [1:0]           CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {S_HOLD, S_PAD, S_RUN, S_FATAL} state_t;

  state_t                 state_q, state_nxt;
  logic [IDX_W-1:0]       idx_q, idx_nxt;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_nxt;
  logic [NUM_DOMAINS-1:0] dom_q, dom_nxt;
  logic                   busy_q, busy_nxt;
  logic [1:0]             cause_q, cause_nxt;
  logic [ESC_W-1:0]       esc_q, esc_nxt;
  logic                   fatal_q, fatal_nxt;
  logic                   wdg_q, wdg_qq, sw_q, sw_qq;

  logic                   wdg_rise, sw_rise;
  logic [CNT_WIDTH-1:0]   hold_cur, hold_last;
  logic [ESC_W-1:0]       esc_inc;

  // State register plus registered outputs and the two-stage edge detectors.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_POR;
      esc_q   <= '0;
      fatal_q <= 1'b0;
      wdg_q   <= 1'b0;
      wdg_qq  <= 1'b0;
      sw_q    <= 1'b0;
      sw_qq   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
      cnt_q   <= cnt_nxt;
      dom_q   <= dom_nxt;
      busy_q  <= busy_nxt;
      cause_q <= cause_nxt;
      esc_q   <= esc_nxt;
      fatal_q <= fatal_nxt;
      wdg_q   <= bus.i_wdg_to;
      wdg_qq  <= wdg_q;
      sw_q    <= bus.i_sw_req;
      sw_qq   <= sw_q;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    dom_nxt   = dom_q;
    cause_nxt = cause_q;
    esc_nxt   = esc_q;
    wdg_rise  = wdg_q & ~wdg_qq;
    sw_rise   = sw_q & ~sw_qq;
    hold_cur  = DOMAIN_HOLD[idx_q*CNT_WIDTH +: CNT_WIDTH];
    hold_last = (hold_cur == '0) ? '0 : hold_cur - CNT_WIDTH'(1);
    esc_inc   = (esc_q == ESC_MAX) ? esc_q : esc_q + ESC_W'(1);

    case (state_q)
      S_HOLD: begin
        if (cnt_q == hold_last) begin
          dom_nxt[idx_q] = 1'b1;
          cnt_nxt        = '0;
          if (idx_q == LAST_IDX) begin
            state_nxt = S_RUN;
          end else if (PADDING_CYCLES == 0) begin
            idx_nxt = idx_q + IDX_W'(1);
          end else begin
            state_nxt = S_PAD;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_PAD: begin
        if (cnt_q == PAD_LAST) begin
          state_nxt = S_HOLD;
          idx_nxt   = idx_q + IDX_W'(1);
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_RUN: begin
        if (bus.i_esc_clr) esc_nxt = '0;
      end
      default: ;
    endcase

    // A trigger restarts from domain 0; the watchdog wins a tie and may escalate.
    if ((state_q != S_FATAL) && (wdg_rise || sw_rise)) begin
      dom_nxt   = '0;
      idx_nxt   = '0;
      cnt_nxt   = '0;
      state_nxt = S_HOLD;
      if (wdg_rise) begin
        cause_nxt = CAUSE_WDG;
        esc_nxt   = esc_inc;
        if (esc_inc == ESC_MAX) state_nxt = S_FATAL;
      end else begin
        cause_nxt = CAUSE_SW;
      end
    end

    if (state_nxt == S_FATAL) dom_nxt = '0;
    busy_nxt  = (state_nxt != S_RUN);
    fatal_nxt = (state_nxt == S_FATAL);
  end

  assign bus.o_dom_res_n = dom_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_cause     = cause_q;
  assign bus.o_esc_cnt   = esc_q;
  assign bus.o_fatal     = fatal_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default 2-domain instance plus a 4-domain,
// zero-padding, zero-hold instance.
module tb_rst_seq_ctrl;

  logic clk;
  logic res_n;
  logic rst2_n;
  int   errors;
  int   checks;

  rst_seq_if #(.NUM_DOMAINS(2), .ESC_LIMIT(3)) bus  ();
  rst_seq_if #(.NUM_DOMAINS(4), .ESC_LIMIT(3)) bus2 ();

  rst_seq_ctrl dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS    (4),
    .CNT_WIDTH      (8),
    .DOMAIN_HOLD    ({8'd1, 8'd2, 8'd0, 8'd3}),
    .PADDING_CYCLES (0),
    .ESC_LIMIT      (3)
  ) dut2 (
    .clk   (clk),
    .res_n (rst2_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle pulse; returns just after the edge that registers the trigger.
  task automatic pulse(input logic w, input logic s);
    bus.i_wdg_to = w;
    bus.i_sw_req = s;
    wait_edges(1);
    bus.i_wdg_to = 1'b0;
    bus.i_sw_req = 1'b0;
    wait_edges(1);
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    wait_edges(3);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL rst_dom: got %b want 00", bus.o_dom_res_n); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL rst_busy: got %b want 1", bus.o_busy); end
    checks++; if (bus.o_cause !== 2'b00) begin errors++; $display("FAIL rst_cause: got %b want 00", bus.o_cause); end
    checks++; if (bus.o_esc_cnt !== 2'd0) begin errors++; $display("FAIL rst_esc: got %0d want 0", bus.o_esc_cnt); end
    checks++; if (bus.o_fatal !== 1'b0) begin errors++; $display("FAIL rst_fatal: got %b want 0", bus.o_fatal); end
  endtask

  task automatic test_power_on();
    res_n = 1'b1;
    wait_edges(4);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL por_e4: got %b want 00", bus.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL por_e5: got %b want 01", bus.o_dom_res_n); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL por_busy_e5: got %b want 1", bus.o_busy); end
    wait_edges(60);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL por_e65: got %b want 01", bus.o_dom_res_n); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL por_busy_e65: got %b want 1", bus.o_busy); end
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL por_e66: got %b want 11", bus.o_dom_res_n); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL por_busy_e66: got %b want 0", bus.o_busy); end
    checks++; if (bus.o_cause !== 2'b00) begin errors++; $display("FAIL por_cause: got %b want 00", bus.o_cause); end
  endtask

  task automatic test_watchdog();
    bus.i_wdg_to = 1'b1;
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL wdg_latency1: got %b want 11", bus.o_dom_res_n); end
    bus.i_wdg_to = 1'b0;
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL wdg_latency2: got %b want 00", bus.o_dom_res_n); end
    checks++; if (bus.o_cause !== 2'b01) begin errors++; $display("FAIL wdg_cause: got %b want 01", bus.o_cause); end
    checks++; if (bus.o_esc_cnt !== 2'd1) begin errors++; $display("FAIL wdg_esc: got %0d want 1", bus.o_esc_cnt); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL wdg_busy: got %b want 1", bus.o_busy); end
    wait_edges(4);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL wdg_e4: got %b want 00", bus.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL wdg_e5: got %b want 01", bus.o_dom_res_n); end
    wait_edges(60);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL wdg_e65: got %b want 01", bus.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL wdg_e66: got %b want 11", bus.o_dom_res_n); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL wdg_busy_e66: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_sw_restart();
    pulse(1'b0, 1'b1);
    checks++; if (bus.o_cause !== 2'b10) begin errors++; $display("FAIL sw_cause: got %b want 10", bus.o_cause); end
    checks++; if (bus.o_esc_cnt !== 2'd1) begin errors++; $display("FAIL sw_esc: got %0d want 1", bus.o_esc_cnt); end
    wait_edges(30);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL sw_mid: got %b want 01", bus.o_dom_res_n); end
    pulse(1'b0, 1'b1);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL sw_restart: got %b want 00", bus.o_dom_res_n); end
    checks++; if (bus.o_esc_cnt !== 2'd1) begin errors++; $display("FAIL sw_restart_esc: got %0d want 1", bus.o_esc_cnt); end
    wait_edges(5);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL sw_rel0: got %b want 01", bus.o_dom_res_n); end
    wait_edges(61);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL sw_rel1: got %b want 11", bus.o_dom_res_n); end
  endtask

  task automatic test_simultaneous();
    pulse(1'b1, 1'b1);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL sim_dom: got %b want 00", bus.o_dom_res_n); end
    checks++; if (bus.o_cause !== 2'b01) begin errors++; $display("FAIL sim_cause: got %b want 01", bus.o_cause); end
    checks++; if (bus.o_esc_cnt !== 2'd2) begin errors++; $display("FAIL sim_esc: got %0d want 2", bus.o_esc_cnt); end
    wait_edges(4);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL sim_e4: got %b want 00", bus.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL sim_e5: got %b want 01", bus.o_dom_res_n); end
    wait_edges(60);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL sim_e65: got %b want 01", bus.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL sim_e66: got %b want 11", bus.o_dom_res_n); end
  endtask

  task automatic test_esc_clear();
    bus.i_esc_clr = 1'b1;
    wait_edges(1);
    bus.i_esc_clr = 1'b0;
    checks++; if (bus.o_esc_cnt !== 2'd0) begin errors++; $display("FAIL clr_esc: got %0d want 0", bus.o_esc_cnt); end
    pulse(1'b1, 1'b0);
    checks++; if (bus.o_esc_cnt !== 2'd1) begin errors++; $display("FAIL clr_wdg_esc: got %0d want 1", bus.o_esc_cnt); end
    checks++; if (bus.o_fatal !== 1'b0) begin errors++; $display("FAIL clr_wdg_fatal: got %b want 0", bus.o_fatal); end
    wait_edges(66);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL clr_rerun: got %b want 11", bus.o_dom_res_n); end
  endtask

  task automatic test_clr_with_trigger();
    bus.i_wdg_to = 1'b1;
    wait_edges(1);
    bus.i_wdg_to  = 1'b0;
    bus.i_esc_clr = 1'b1;
    wait_edges(1);
    bus.i_esc_clr = 1'b0;
    checks++; if (bus.o_esc_cnt !== 2'd2) begin errors++; $display("FAIL clrtrig_esc: got %0d want 2", bus.o_esc_cnt); end
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL clrtrig_dom: got %b want 00", bus.o_dom_res_n); end
    checks++; if (bus.o_fatal !== 1'b0) begin errors++; $display("FAIL clrtrig_fatal: got %b want 0", bus.o_fatal); end
    wait_edges(66);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL clrtrig_rerun: got %b want 11", bus.o_dom_res_n); end
  endtask

  task automatic test_level_hold();
    bus.i_sw_req = 1'b1;
    wait_edges(2);
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL lvl_dom: got %b want 00", bus.o_dom_res_n); end
    checks++; if (bus.o_cause !== 2'b10) begin errors++; $display("FAIL lvl_cause: got %b want 10", bus.o_cause); end
    wait_edges(66);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL lvl_single: got %b want 11", bus.o_dom_res_n); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL lvl_busy: got %b want 0", bus.o_busy); end
    bus.i_sw_req = 1'b0;
    wait_edges(3);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL lvl_fall: got %b want 11", bus.o_dom_res_n); end
  endtask

  task automatic test_fatal();
    res_n = 1'b0;
    wait_edges(1);
    res_n = 1'b1;
    wait_edges(66);
    pulse(1'b1, 1'b0);
    checks++; if (bus.o_esc_cnt !== 2'd1) begin errors++; $display("FAIL fat_esc1: got %0d want 1", bus.o_esc_cnt); end
    pulse(1'b1, 1'b0);
    checks++; if (bus.o_fatal !== 1'b0) begin errors++; $display("FAIL fat_early: got %b want 0", bus.o_fatal); end
    pulse(1'b1, 1'b0);
    checks++; if (bus.o_fatal !== 1'b1) begin errors++; $display("FAIL fat_enter: got %b want 1", bus.o_fatal); end
    checks++; if (bus.o_esc_cnt !== 2'd3) begin errors++; $display("FAIL fat_esc3: got %0d want 3", bus.o_esc_cnt); end
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL fat_dom: got %b want 00", bus.o_dom_res_n); end
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    bus.i_esc_clr = 1'b1;
    wait_edges(80);
    bus.i_esc_clr = 1'b0;
    checks++; if (bus.o_fatal !== 1'b1) begin errors++; $display("FAIL fat_hold: got %b want 1", bus.o_fatal); end
    checks++; if (bus.o_dom_res_n !== 2'b00) begin errors++; $display("FAIL fat_hold_dom: got %b want 00", bus.o_dom_res_n); end
    checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL fat_busy: got %b want 1", bus.o_busy); end
    checks++; if (bus.o_esc_cnt !== 2'd3) begin errors++; $display("FAIL fat_hold_esc: got %0d want 3", bus.o_esc_cnt); end
    res_n = 1'b0;
    #1;
    checks++; if (bus.o_fatal !== 1'b0) begin errors++; $display("FAIL fat_async_fatal: got %b want 0", bus.o_fatal); end
    checks++; if (bus.o_esc_cnt !== 2'd0) begin errors++; $display("FAIL fat_async_esc: got %0d want 0", bus.o_esc_cnt); end
    checks++; if (bus.o_cause !== 2'b00) begin errors++; $display("FAIL fat_async_cause: got %b want 00", bus.o_cause); end
    wait_edges(1);
    res_n = 1'b1;
    wait_edges(5);
    checks++; if (bus.o_dom_res_n !== 2'b01) begin errors++; $display("FAIL fat_por_e5: got %b want 01", bus.o_dom_res_n); end
    wait_edges(61);
    checks++; if (bus.o_dom_res_n !== 2'b11) begin errors++; $display("FAIL fat_por_e66: got %b want 11", bus.o_dom_res_n); end
  endtask

  task automatic test_sweep();
    checks++; if (bus2.o_dom_res_n !== 4'b0000) begin errors++; $display("FAIL swp_rst: got %b want 0000", bus2.o_dom_res_n); end
    rst2_n = 1'b1;
    wait_edges(2);
    checks++; if (bus2.o_dom_res_n !== 4'b0000) begin errors++; $display("FAIL swp_e2: got %b want 0000", bus2.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus2.o_dom_res_n !== 4'b0001) begin errors++; $display("FAIL swp_e3: got %b want 0001", bus2.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus2.o_dom_res_n !== 4'b0011) begin errors++; $display("FAIL swp_e4_zero_hold: got %b want 0011", bus2.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus2.o_dom_res_n !== 4'b0011) begin errors++; $display("FAIL swp_e5: got %b want 0011", bus2.o_dom_res_n); end
    wait_edges(1);
    checks++; if (bus2.o_dom_res_n !== 4'b0111) begin errors++; $display("FAIL swp_e6: got %b want 0111", bus2.o_dom_res_n); end
    checks++; if (bus2.o_busy !== 1'b1) begin errors++; $display("FAIL swp_busy_e6: got %b want 1", bus2.o_busy); end
    wait_edges(1);
    checks++; if (bus2.o_dom_res_n !== 4'b1111) begin errors++; $display("FAIL swp_e7: got %b want 1111", bus2.o_dom_res_n); end
    checks++; if (bus2.o_busy !== 1'b0) begin errors++; $display("FAIL swp_busy_e7: got %b want 0", bus2.o_busy); end
  endtask

  initial begin
    clk            = 1'b0;
    res_n          = 1'b0;
    rst2_n         = 1'b0;
    errors         = 0;
    checks         = 0;
    bus.i_wdg_to   = 1'b0;
    bus.i_sw_req   = 1'b0;
    bus.i_esc_clr  = 1'b0;
    bus2.i_wdg_to  = 1'b0;
    bus2.i_sw_req  = 1'b0;
    bus2.i_esc_clr = 1'b0;
    test_reset();
    test_power_on();
    test_watchdog();
    test_sw_restart();
    test_simultaneous();
    test_esc_clear();
    test_clr_with_trigger();
    test_level_hold();
    test_fatal();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Parametrised multi-domain reset sequencer, the successor to the two-output watchdog/core reset controller. It holds NUM_DOMAINS reset domains in reset and releases them in ascending index order with programmable hold and padding times. Restarts come from power-on, a watchdog timeout or a software request. It records the cause of the last reset and escalates to a latched fatal state after ESC_LIMIT watchdog resets without a software clear. It sits between the board reset and the SoC: domain 0 is the watchdog, domain 1 is the core, and higher domains are peripherals.

## Interface
- NUM_DOMAINS, 2: number of reset domains, ≥1.
- CNT_WIDTH, 8: width of the hold/padding counter.
- DOMAIN_HOLD, {8'd60, 8'd5}: packed NUM_DOMAINS×CNT_WIDTH. Field k is the hold cycles of domain k; the value 0 is treated as 1.
- PADDING_CYCLES, 1: gap cycles between consecutive releases, ≥0, < 2^CNT_WIDTH.
- ESC_LIMIT, 3: watchdog-triggered sequences that cause FATAL, ≥1.
- clk  in  1  system clock.
- res_n  in  1  asynchronous active-low reset (board/power-on).
- i_wdg_to  in  1  watchdog timeout level; rising edge triggers.
- i_sw_req  in  1  software reset request level; rising edge triggers.
- i_esc_clr  in  1  clears the escalation counter; honoured in RUN only.
- o_dom_res_n  out  NUM_DOMAINS  per-domain active-low resets, registered.
- o_busy  out  1  high while any domain is held in reset.
- o_cause  out  2  cause of the last sequence: 00 power-on, 01 watchdog, 10 software.
- o_esc_cnt  out  $clog2(ESC_LIMIT+1)  watchdog resets since the last clear.
- o_fatal  out  1  latched escalation.

## Operation
- The FSM has four states: HOLD, PAD, RUN and FATAL. A domain index idx and a counter cnt (CNT_WIDTH) are held alongside the state.
- Reset (res_n low) forces:
  - state = HOLD, idx = 0, cnt = 0;
  - o_dom_res_n = 0, o_busy = 1, o_cause = 00, o_esc_cnt = 0, o_fatal = 0;
  - edge-detect registers = 0.
- HOLD:
  - cnt increments each cycle.
  - When cnt reaches hold(idx)−1, o_dom_res_n[idx] is set and cnt is cleared.
  - If idx = NUM_DOMAINS−1, the FSM goes to RUN. Otherwise it goes to PAD, or straight to HOLD with idx+1 when PADDING_CYCLES = 0.
- PAD:
  - cnt counts PADDING_CYCLES cycles.
  - The FSM then goes to HOLD with idx+1 and cnt = 0.
- RUN:
  - o_busy = 0.
  - i_esc_clr sets o_esc_cnt to 0.
- Trigger means a rising edge of i_wdg_to or i_sw_req. The edge is detected against the previous-cycle register.
- On a trigger in HOLD, PAD or RUN:
  - all o_dom_res_n go to 0 on the next edge;
  - idx and cnt are cleared and the FSM enters HOLD;
  - o_busy goes to 1 and o_cause is updated.
- A trigger during an ongoing sequence restarts it from domain 0.
- Simultaneous watchdog and software edges: watchdog wins (cause 01), and only one restart occurs.
- Watchdog trigger escalation:
  - o_esc_cnt increments, saturating at ESC_LIMIT.
  - If the new value equals ESC_LIMIT, the FSM enters FATAL instead of HOLD.
- Software triggers do not change o_esc_cnt.
- FATAL:
  - all domains are held in reset, o_busy = 1, o_fatal = 1;
  - all triggers and i_esc_clr are ignored;
  - only res_n exits this state.
- i_esc_clr in the same cycle as a watchdog trigger in RUN: the trigger wins and the counter increments from its current value.

## Timing
- Release of domain k happens Σ_{j≤k} hold(j) + k·PADDING_CYCLES rising edges after the first rising edge with res_n high, or after the edge that registers a trigger.
- Default release times: domain 0 at 5 cycles, domain 1 at 5 + 1 + 60 = 66 cycles.
- Trigger latency: an input edge sampled at edge n gives o_dom_res_n = 0 after edge n+1. There is one cycle for edge detection and one cycle of output register.
- o_busy, o_cause and o_esc_cnt change on the same edge as o_dom_res_n.
- Level inputs held high cause exactly one trigger. A new trigger requires a low cycle first.
- res_n assertion mid-sequence or in FATAL clears everything asynchronously.

## Test plan
- Power-on with defaults: release res_n → o_dom_res_n[0] rises at cycle 5, o_dom_res_n[1] at cycle 66, o_busy falls at 66, o_cause = 00.
- Watchdog pulse in RUN → both domains low 2 edges later; o_cause = 01, o_esc_cnt = 1; re-release at +5 and +66 cycles.
- Software request at cycle 30 of a sequence (domain 1 still held) → domain 0 drops again; the sequence restarts; o_cause = 10; o_esc_cnt unchanged.
- Simultaneous i_wdg_to and i_sw_req edges → a single restart with o_cause = 01.
- Three watchdog timeouts without i_esc_clr (ESC_LIMIT = 3) → o_fatal = 1 and all domains held. Further triggers and i_esc_clr are ignored. Pulsing res_n returns to power-on behaviour with o_esc_cnt = 0.
- Two watchdog timeouts, then i_esc_clr in RUN → o_esc_cnt = 0. A third timeout gives o_esc_cnt = 1 and no FATAL.
- Parameter sweep: NUM_DOMAINS = 4, PADDING_CYCLES = 0, a hold field of 0 → releases are back-to-back and the zero-hold domain releases 1 cycle after its predecessor.
